// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the word-addressed memory bus initiator.
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic MEM_RW_READ  = 1'b1;
    localparam logic MEM_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RCAPT,
        ST_WRITE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_bus_master.sv
// Single-outstanding load/store initiator: core valid/ready request in,
// registered memory control plus tri-state data bus out, one completion per request.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_write,
    output logic              mem_enable,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t              state;
    state_t              state_next;
    logic                write_q;
    logic                data_oe;
    logic [DATA_W-1:0]   wdata_q;
    logic                xfer;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_write = write_q;
    assign xfer      = req_valid && req_ready;

    // Only this register can enable the master driver, and it is high for WRITE only.
    assign mem_data = data_oe ? wdata_q : {DATA_W{1'bz}};

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (req_valid) state_next = req_write ? ST_WRITE : ST_READ;
            ST_READ:  state_next = ST_RCAPT;
            ST_RCAPT: state_next = ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus controls are registered off the next state so they line up with the state cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_address    <= '0;
            mem_read_write <= MEM_RW_READ;
            mem_enable     <= 1'b0;
            data_oe        <= 1'b0;
            wdata_q        <= '0;
            write_q        <= 1'b0;
            rsp_rdata      <= '0;
        end else begin
            mem_enable     <= (state_next == ST_READ) || (state_next == ST_WRITE);
            mem_read_write <= (state_next == ST_WRITE) ? MEM_RW_WRITE : MEM_RW_READ;
            data_oe        <= (state_next == ST_WRITE);
            if (xfer) begin
                mem_address <= req_addr;
                wdata_q     <= req_wdata;
                write_q     <= req_write;
            end
            if (state == ST_RCAPT) begin
                rsp_rdata <= mem_data;
            end else if (state == ST_WRITE) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: transaction-level reference model with a per-cycle
// compare process, a simple synchronous memory on the shared bus, and directed tests.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_address;
    logic        mem_read_write;
    logic        mem_enable;
    wire  [15:0] mem_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_enable(mem_enable), .mem_data(mem_data)
    );

    // Memory: samples a read with enable high, drives the word the following cycle.
    logic [15:0] mem_arr [0:65535];
    logic        mem_drive = 1'b0;
    logic [15:0] mem_q = '0;
    assign mem_data = mem_drive ? mem_q : 16'hzzzz;

    always @(posedge clk) begin
        mem_drive <= mem_enable && mem_read_write;
        mem_q     <= mem_arr[mem_address];
        if (mem_enable && !mem_read_write) mem_arr[mem_address] <= mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one accepted request in flight, aged in cycles since accept.
    logic [15:0] ref_mem [0:65535];
    int          cyc = 0;
    int          m_acc_cyc = 0;
    logic        m_rst = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_write = 1'b0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;
    logic [15:0] m_last_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_rst       <= 1'b1;
            m_busy      <= 1'b0;
            m_last_addr <= '0;
        end else begin
            m_rst <= 1'b0;
            if (m_busy && rsp_ready && rsp_valid) m_busy <= 1'b0;
            if (req_valid && !m_busy) begin
                m_busy      <= 1'b1;
                m_acc_cyc   <= cyc;
                m_write     <= req_write;
                m_wdata     <= req_wdata;
                m_last_addr <= req_addr;
                m_rdata     <= req_write ? 16'h0000 : ref_mem[req_addr];
                if (req_write) ref_mem[req_addr] <= req_wdata;
            end
        end
    end

    int age;
    always @(negedge clk) begin
        check("no_contention", 32'(dut.data_oe && mem_drive), 0);
        if (m_rst) begin
            check("rst_req_ready", 32'(req_ready), 1);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_write", 32'(rsp_write), 0);
            check("rst_rsp_rdata", 32'(rsp_rdata), 0);
            check("rst_mem_address", 32'(mem_address), 0);
            check("rst_mem_rw", 32'(mem_read_write), 1);
            check("rst_mem_enable", 32'(mem_enable), 0);
            check("rst_oe", 32'(dut.data_oe), 0);
        end else begin
            check("addr_hold", 32'(mem_address), 32'(m_last_addr));
            if (!m_busy) begin
                check("idle_req_ready", 32'(req_ready), 1);
                check("idle_rsp_valid", 32'(rsp_valid), 0);
                check("idle_enable", 32'(mem_enable), 0);
                check("idle_rw", 32'(mem_read_write), 1);
                check("idle_oe", 32'(dut.data_oe), 0);
            end else begin
                age = cyc - m_acc_cyc;
                check("busy_req_ready", 32'(req_ready), 0);
                check("enable", 32'(mem_enable), 32'(age == 1));
                check("rw", 32'(mem_read_write), 32'(!(age == 1 && m_write)));
                check("oe", 32'(dut.data_oe), 32'(age == 1 && m_write));
                if (age == 1 && m_write) check("bus_wdata", 32'(mem_data), 32'(m_wdata));
                if (age == 2 && !m_write) check("bus_known", 32'($isunknown(mem_data)), 0);
                check("rsp_valid", 32'(rsp_valid), 32'(age >= (m_write ? 2 : 3)));
                if (rsp_valid) begin
                    check("rsp_write", 32'(rsp_write), 32'(m_write));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
                end
            end
        end
    end

    // Issue one request with rsp_ready high; returns latency to rsp_valid and
    // the bus values seen in the first access cycle.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat,
                          output logic en1, output logic rw1, output logic [15:0] bus1);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_write = ~w;
        lat = 0; rd = '0; en1 = 1'b0; rw1 = 1'b0; bus1 = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin en1 = mem_enable; rw1 = mem_read_write; bus1 = mem_data; end
        end while (!rsp_valid && lat < 10);
        if (!rsp_valid) check("req_timeout", 32'(rsp_valid), 1);
        rd = rsp_rdata;
    endtask

    logic [15:0] rd, bus1;
    logic        en1, rw1;
    int          lat, n;

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oe_lit", 32'(dut.data_oe), 0);
        check("rst_en_lit", 32'(mem_enable), 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 1);

        do_req(1'b1, 16'h0012, 16'hBEEF, rd, lat, en1, rw1, bus1);
        check("st_lat", 32'(lat), 2);
        check("st_en", 32'(en1), 1);
        check("st_rw", 32'(rw1), 0);
        check("st_bus", 32'(bus1), 32'hBEEF);
        check("st_rdata", 32'(rd), 0);
        do_req(1'b0, 16'h0012, 16'h0000, rd, lat, en1, rw1, bus1);
        check("ld_lat", 32'(lat), 3);
        check("ld_rw", 32'(rw1), 1);
        check("ld_rdata", 32'(rd), 32'hBEEF);

        do_req(1'b1, 16'h0000, 16'h1234, rd, lat, en1, rw1, bus1);
        do_req(1'b1, 16'hFFFF, 16'h5678, rd, lat, en1, rw1, bus1);
        do_req(1'b0, 16'h0000, 16'h0000, rd, lat, en1, rw1, bus1);
        check("ld_addr0", 32'(rd), 32'h1234);
        do_req(1'b0, 16'hFFFF, 16'h0000, rd, lat, en1, rw1, bus1);
        check("ld_addrmax", 32'(rd), 32'h5678);

        // Completion stall with a second request waiting on req_valid.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0012; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h00AA;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        check("stall_lat", 32'(n), 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_rdata", 32'(rsp_rdata), 32'hBEEF);
            check("stall_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("after_hs_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("next_accept_en", 32'(mem_enable), 1);
        check("next_accept_rw", 32'(mem_read_write), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        check("next_store_done", 32'(rsp_valid), 1);

        // Back-to-back alternating stores and loads.
        for (int i = 0; i < 8; i++) begin
            do_req(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), rd, lat, en1, rw1, bus1);
            do_req(1'b0, 16'h0100 + 16'(i), 16'h0000, rd, lat, en1, rw1, bus1);
            check("b2b_rdata", 32'(rd), 32'hA000 + 32'(i));
        end
        check("b2b_last_lat", 32'(lat), 3);

        // Reset while the load is in its capture cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0012;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_en", 32'(mem_enable), 0);
        check("midrst_ready", 32'(req_ready), 1);
        check("midrst_valid", 32'(rsp_valid), 0);
        reset = 1'b1;
        n = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) n++; end
        check("midrst_no_rsp", 32'(n), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator for the word-addressed synchronous memory. It accepts single load/store requests from the CPU core over a valid/ready handshake and drives the memory's `address`, `read_write`, `enable` and bidirectional 16-bit `data` lines. It captures read data and returns one completion per request to the core. It sits between the core's memory stage and the memory block, and is the only driver of the memory-side control lines.

## Interface
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: data word width.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  completion present; held until `rsp_ready`.
- `rsp_ready`  in  1  core accepts completion.
- `rsp_write`  out  1  completion is for a store.
- `rsp_rdata`  out  DATA_W  load data; 0 for stores.
- `mem_address`  out  ADDR_W  registered address to memory.
- `mem_read_write`  out  1  1 = read, 0 = write.
- `mem_enable`  out  1  memory access strobe.
- `mem_data`  inout  DATA_W  driven only in WRITE, else high-Z.

## Operation
- States: IDLE, READ, RCAPT, WRITE, RESP.
- IDLE:
  - `req_ready=1`.
  - On transfer, register addr, wdata and write flag.
  - Go to WRITE if store, else READ.
- READ (1 cycle):
  - `mem_enable=1`, `mem_read_write=1`, `mem_data` released.
  - Memory samples at the closing edge.
  - Go to RCAPT.
- RCAPT (1 cycle):
  - `mem_enable=0`, `mem_read_write=1`.
  - Memory drives the word during this cycle.
  - Register `mem_data` into `rsp_rdata` at the closing edge.
  - Go to RESP.
- WRITE (1 cycle):
  - `mem_enable=1`, `mem_read_write=0`, data output-enable=1 with registered wdata on `mem_data`.
  - Memory writes at the closing edge.
  - Clear `rsp_rdata` to 0.
  - Go to RESP.
- RESP:
  - `rsp_valid=1`.
  - `rsp_write` and `rsp_rdata` stable until handshake.
  - On `rsp_ready`, go to IDLE.
- No new request is accepted before the completion handshake; one outstanding access maximum.
- `mem_address` holds its last value outside accesses.
- `mem_read_write` idles at 1 (read), so the memory never sees a write with enable low.
- Output-enable is a registered signal, high only in WRITE. Bus turnaround is guaranteed because READ/RCAPT/RESP/IDLE separate every write from the memory's drive window.
- Addresses are used as-is: no width conversion and no wrap logic. Full `ADDR_W` range is legal, including 0 and 2^ADDR_W−1.

## Timing
- Reset values:
  - state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_write=0`, `rsp_rdata=0`.
  - `mem_address=0`, `mem_read_write=1`, `mem_enable=0`, `mem_data` high-Z.
- Reset low mid-operation returns all outputs to reset values at the next edge.
  - The in-flight request is dropped with no completion.
  - A write in progress at that edge is not guaranteed to commit.
- Load latency: request accepted at edge E0. `mem_enable` is high in cycle E0→E1, data is captured at E2, and `rsp_valid` rises after E2. Total 3 cycles to completion.
- Store latency: accepted at E0, `mem_enable` high E0→E1, `rsp_valid` rises after E1. Total 2 cycles.
- `rsp_ready` held high yields back-to-back throughput: one load per 4 cycles, one store per 3 cycles (RESP→IDLE costs one cycle).
- `rsp_ready` asserted before `rsp_valid` has no effect.
- `req_*` inputs are sampled only at the transfer edge; later changes are ignored.

## Structure
- Shared package `mem_bus_pkg`:
  - state enum (IDLE, READ, RCAPT, WRITE, RESP).
  - constants `MEM_RW_READ=1'b1`, `MEM_RW_WRITE=1'b0`.
  - default `ADDR_W`/`DATA_W`.
- Single flat module. The tri-state assign stays at top level with no separate sub-module, so the output-enable register stays visible to the bench.

## Test plan
- Reset: hold `reset=0` for 3 cycles → all outputs at reset values and `mem_data` high-Z; release → `req_ready=1`.
- Store then load: store 0xBEEF to 0x0012, then load 0x0012 against the memory model.
  - Store: `mem_enable` high one cycle with `mem_read_write=0` and `mem_data=0xBEEF`; `rsp_valid` rises 2 cycles after accept.
  - Load: `rsp_rdata=0xBEEF` 3 cycles after accept.
- Address extremes: store 0x1234 to 0x0000 and 0x5678 to 0xFFFF, then load both → 0x1234 and 0x5678; no aliasing.
- Completion stall: load with `rsp_ready=0` for 5 cycles.
  - `rsp_valid`/`rsp_rdata` stay constant and `req_ready=0` with `req_valid` held high.
  - After `rsp_ready=1`, the next request is accepted exactly 1 cycle later.
- Bus contention check: alternate 8 stores/loads back-to-back with `rsp_ready=1`. Master output-enable and memory drive are never active in the same cycle; no X on `mem_data`.
- Reset mid-load: drop `reset` in RCAPT → next edge gives IDLE with `mem_enable=0`, no `rsp_valid` ever asserted for that load.
